// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier for the execute stage.
//   Takes one multiplier bit per cycle, so a multiply costs WIDTH+2 cycles
//   from the start edge to the first cycle the result is visible.
//   Signed operands are reduced to magnitudes up front. The sign is applied
//   once, at the end, to the full 2*WIDTH product.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      start request; only looked at while idle
//   is_signed  1 = two's-complement operands (MULT), 0 = unsigned (MULTU)
//   a, b       multiplicand / multiplier, sampled on the start edge only
//   hi, lo     registered product upper / lower halves; held until the next result
//   busy       registered, high while a multiply is in flight (pipeline stall)
//   done       one-cycle pulse when hi/lo first show a new result
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;   // holds ma << (WIDTH - count) for the current step
    logic [WIDTH-1:0]   mb;
    logic [CW-1:0]      count;
    logic               neg;

    // The magnitude of the most-negative value wraps to itself. Read as an
    // unsigned number, that is exactly 2^(WIDTH-1), so no extra bit is needed.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            mb    <= '0;
            count <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, a_mag};
                        mb    <= b_mag;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The loop always runs the full WIDTH steps, so latency is fixed.
                    if (mb[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mb    <= mb >> 1;
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    {hi, lo} <= neg ? (~acc + 1'b1) : acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
